timekeeper_core: RTL and testbench

//  Parametrised HH:MM:SS timekeeping core for the clock display path: own prescaler-driven 1 Hz tick,
//  sec/min/hour counters, field-addressed set handshake with range check, 12/24 h display with PM flag,

---
 rtl/timekeeper_pkg.sv | 25 ++
 rtl/bin2bcd_6b.sv | 24 ++
 rtl/timekeeper_core.sv | 195 +++++++++++++++++++
 tb/tb_timekeeper_core.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// Shared definitions for the timekeeping core: time field width, field
// select codes for the set handshake, FSM state type and the sec/min limits.
package timekeeper_pkg;

  localparam int unsigned TF_W = 6;
  typedef logic [TF_W-1:0] tfield_t;

  localparam tfield_t SEC_LIMIT = 6'd60;
  localparam tfield_t MIN_LIMIT = 6'd60;
  localparam tfield_t SEC_LAST  = 6'd59;
  localparam tfield_t MIN_LAST  = 6'd59;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2,
    FLD_RSVD = 2'd3
  } field_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_e;

endpackage

// File: rtl/bin2bcd_6b.sv
// 6-bit binary to two-digit BCD converter, purely combinational.
// Ports:
//   bin_i  in  6  binary value (0..63)
//   bcd_o  out 8  {tens, ones}
// Built as a compare-equal lookup so no divider or subtract chain is inferred.
module bin2bcd_6b
  import timekeeper_pkg::*;
(
  input  logic [TF_W-1:0] bin_i,
  output logic [7:0]      bcd_o
);

  always_comb begin
    bcd_o = '0;
    for (int unsigned t = 0; t < 7; t++) begin
      for (int unsigned o = 0; o < 10; o++) begin
        if (32'(bin_i) == (t * 10 + o)) begin
          bcd_o = {4'(t), 4'(o)};
        end
      end
    end
  end

endmodule

// File: rtl/timekeeper_core.sv
// HH:MM:SS timekeeping core: prescaler-driven 1 Hz tick, sec/min/hour
// counters, field-addressed set handshake with range check, 12/24 h display
// with PM flag and a registered day-rollover pulse.
// Optional feature macro: TIMEKEEPER_ALARM_EN (adds alarm_hour/alarm_min/
// alarm_arm inputs and the alarm_fire pulse output).
// Ports:
//   CLOCK_50MHz  in   system clock (rising edge)
//   RESET        in   asynchronous active-high reset
//   run_en       in   prescaler advance enable (freeze, not clear)
//   set_req      in   request SET state
//   set_field    in   0 sec, 1 min, 2 hour, 3 reserved
//   set_value    in   value written by set_strobe
//   set_strobe   in   write strobe (SET state only)
//   set_commit   in   leave SET, restart prescaler
//   mode_12h     in   12 h display select
//   hour_bcd/min_bcd/sec_bcd out  BCD display digits
//   is_pm        out  internal hour >= 12
//   tick_1hz     out  one-cycle pulse per second
//   day_pulse    out  one-cycle pulse on day rollover
//   setting      out  high in SET state
//   set_err      out  one-cycle pulse on rejected strobe
module timekeeper_core
  import timekeeper_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned HOURS_DAY = 24,
  parameter int unsigned PRESC_W   = 26
) (
  input  logic            CLOCK_50MHz,
  input  logic            RESET,
  input  logic            run_en,
  input  logic            set_req,
  input  logic [1:0]      set_field,
  input  logic [5:0]      set_value,
  input  logic            set_strobe,
  input  logic            set_commit,
  input  logic            mode_12h,
`ifdef TIMEKEEPER_ALARM_EN
  input  logic [5:0]      alarm_hour,
  input  logic [5:0]      alarm_min,
  input  logic [0:0]      alarm_arm,
  output logic [0:0]      alarm_fire,
`endif
  output logic [7:0]      hour_bcd,
  output logic [7:0]      min_bcd,
  output logic [7:0]      sec_bcd,
  output logic            is_pm,
  output logic            tick_1hz,
  output logic            day_pulse,
  output logic            setting,
  output logic            set_err
);

  localparam logic [PRESC_W-1:0] PRESC_TC   = PRESC_W'(CLK_HZ - 1);
  localparam tfield_t            HOUR_LAST  = TF_W'(HOURS_DAY - 1);
  localparam logic [TF_W:0]      HOUR_LIMIT = (TF_W + 1)'(HOURS_DAY);

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  tfield_t              sec_q, sec_d;
  tfield_t              min_q, min_d;
  tfield_t              hour_q, hour_d;
  logic                 tick_q, tick_d;
  logic                 day_q, day_d;
  logic                 err_q, err_d;
  logic                 setting_q, setting_d;
`ifdef TIMEKEEPER_ALARM_EN
  logic                 alarm_q, alarm_d;
`endif

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    tick_d   = 1'b0;
    day_d    = 1'b0;
    err_d    = 1'b0;
`ifdef TIMEKEEPER_ALARM_EN
    alarm_d  = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (run_en) begin
          if (presc_q == PRESC_TC) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_q == SEC_LAST) begin
              sec_d = '0;
              if (min_q == MIN_LAST) begin
                min_d = '0;
                if (hour_q == HOUR_LAST) begin
                  hour_d = '0;
                  day_d  = 1'b1;
                end else begin
                  hour_d = hour_q + tfield_t'(1);
                end
              end else begin
                min_d = min_q + tfield_t'(1);
              end
            end else begin
              sec_d = sec_q + tfield_t'(1);
            end
`ifdef TIMEKEEPER_ALARM_EN
            alarm_d = alarm_arm[0] && (sec_d == '0) && (min_d == alarm_min) &&
                      (hour_d == alarm_hour);
`endif
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        // Any tick due this cycle has already been folded into the _d values.
        if (set_req) begin
          state_d = ST_SET;
          presc_d = '0;
        end
      end
      ST_SET: begin
        presc_d = '0;
        if (set_strobe) begin
          case (field_e'(set_field))
            FLD_SEC:  if (set_value < SEC_LIMIT) sec_d = set_value; else err_d = 1'b1;
            FLD_MIN:  if (set_value < MIN_LIMIT) min_d = set_value; else err_d = 1'b1;
            FLD_HOUR: if ({1'b0, set_value} < HOUR_LIMIT) hour_d = set_value; else err_d = 1'b1;
            FLD_RSVD: err_d = 1'b1;
          endcase
        end
        if (set_commit) begin
          state_d = ST_RUN;
        end
      end
    endcase
    setting_d = (state_d == ST_SET);
  end

  always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_RUN;
      presc_q   <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      tick_q    <= 1'b0;
      day_q     <= 1'b0;
      err_q     <= 1'b0;
      setting_q <= 1'b0;
`ifdef TIMEKEEPER_ALARM_EN
      alarm_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      tick_q    <= tick_d;
      day_q     <= day_d;
      err_q     <= err_d;
      setting_q <= setting_d;
`ifdef TIMEKEEPER_ALARM_EN
      alarm_q   <= alarm_d;
`endif
    end
  end

  // 12 h mapping: 0 -> 12, 13.. -> hour-12 via compare-equal lookup.
  tfield_t hour_disp;
  always_comb begin
    hour_disp = hour_q;
    if (mode_12h) begin
      if (hour_q == '0) begin
        hour_disp = 6'd12;
      end else if (hour_q > 6'd12) begin
        for (int unsigned k = 1; k <= 51; k++) begin
          if (hour_q == TF_W'(k + 12)) hour_disp = TF_W'(k);
        end
      end
    end
  end

  bin2bcd_6b u_hour_bcd (.bin_i(hour_disp), .bcd_o(hour_bcd));
  bin2bcd_6b u_min_bcd  (.bin_i(min_q),     .bcd_o(min_bcd));
  bin2bcd_6b u_sec_bcd  (.bin_i(sec_q),     .bcd_o(sec_bcd));

  assign is_pm     = (hour_q >= 6'd12);
  assign tick_1hz  = tick_q;
  assign day_pulse = day_q;
  assign setting   = setting_q;
  assign set_err   = err_q;
`ifdef TIMEKEEPER_ALARM_EN
  assign alarm_fire = alarm_q;
`endif

endmodule

// File: tb/tb_timekeeper_core.sv
module tb_timekeeper_core;

  localparam int unsigned CLK   = 10;
  localparam int unsigned HOURS = 24;
  localparam int unsigned DAY_S = HOURS * 3600;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en, set_req, set_strobe, set_commit, mode_12h;
  logic [1:0] set_field;
  logic [5:0] set_value;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       is_pm, tick_1hz, day_pulse, setting, set_err;
`ifdef TIMEKEEPER_ALARM_EN
  logic [5:0] alarm_hour, alarm_min;
  logic [0:0] alarm_arm;
  logic [0:0] alarm_fire;
`endif

  always #5 clk = ~clk;

  timekeeper_core #(.CLK_HZ(10), .HOURS_DAY(24), .PRESC_W(4)) dut (
    .CLOCK_50MHz(clk),
    .RESET(rst),
    .run_en(run_en),
    .set_req(set_req),
    .set_field(set_field),
    .set_value(set_value),
    .set_strobe(set_strobe),
    .set_commit(set_commit),
    .mode_12h(mode_12h),
`ifdef TIMEKEEPER_ALARM_EN
    .alarm_hour(alarm_hour),
    .alarm_min(alarm_min),
    .alarm_arm(alarm_arm),
    .alarm_fire(alarm_fire),
`endif
    .hour_bcd(hour_bcd),
    .min_bcd(min_bcd),
    .sec_bcd(sec_bcd),
    .is_pm(is_pm),
    .tick_1hz(tick_1hz),
    .day_pulse(day_pulse),
    .setting(setting),
    .set_err(set_err)
  );

  // Behavioural model: seconds-of-day, cycles since last second, SET flag.
  int unsigned tod, pcnt;
  bit          m_set, e_tick, e_day, e_err, e_fire, model_on;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned to_bcd(input int unsigned v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int unsigned disp_hour(input int unsigned h, input bit m12);
    if (!m12) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  task automatic model_reset();
    tod = 0; pcnt = 0; m_set = 0;
    e_tick = 0; e_day = 0; e_err = 0; e_fire = 0;
  endtask

  // Called right after a rising edge, with the inputs that edge sampled.
  task automatic model_next();
    int unsigned h, m, s;
    e_tick = 0; e_day = 0; e_err = 0; e_fire = 0;
    if (!m_set) begin
      if (run_en) begin
        if (pcnt == CLK - 1) begin
          pcnt   = 0;
          e_tick = 1;
          tod    = (tod + 1) % DAY_S;
          if (tod == 0) e_day = 1;
`ifdef TIMEKEEPER_ALARM_EN
          if (alarm_arm == 1'b1 && tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60) e_fire = 1;
`endif
        end else begin
          pcnt++;
        end
      end
      if (set_req) begin
        m_set = 1;
        pcnt  = 0;
      end
    end else begin
      h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
      if (set_strobe) begin
        case (int'(set_field))
          0: if (int'(set_value) < 60) s = set_value; else e_err = 1;
          1: if (int'(set_value) < 60) m = set_value; else e_err = 1;
          2: if (int'(set_value) < HOURS) h = set_value; else e_err = 1;
          default: e_err = 1;
        endcase
      end
      tod = h * 3600 + m * 60 + s;
      if (set_commit) begin
        m_set = 0;
        pcnt  = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_next();
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_hour", hour_bcd, mode_12h ? 8'h12 : 8'h00);
    chk("rst_setting", setting, 1'b0);
    chk("rst_tick", tick_1hz, 1'b0);
    chk("rst_err", set_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic strobe(input int unsigned f, input int unsigned v);
    set_strobe = 1'b1;
    set_field  = 2'(f);
    set_value  = 6'(v);
    step();
    set_strobe = 1'b0;
  endtask

  // Compare process: every cycle the DUT against the model.
  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("hour_bcd", hour_bcd, to_bcd(disp_hour(tod / 3600, mode_12h)));
      chk("min_bcd", min_bcd, to_bcd((tod / 60) % 60));
      chk("sec_bcd", sec_bcd, to_bcd(tod % 60));
      chk("is_pm", is_pm, (tod / 3600) >= 12);
      chk("tick_1hz", tick_1hz, e_tick);
      chk("day_pulse", day_pulse, e_day);
      chk("setting", setting, m_set);
      chk("set_err", set_err, e_err);
`ifdef TIMEKEEPER_ALARM_EN
      chk("alarm_fire", alarm_fire, e_fire);
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run_en = 0; set_req = 0; set_strobe = 0; set_commit = 0;
    mode_12h = 0; set_field = '0; set_value = '0;
`ifdef TIMEKEEPER_ALARM_EN
    alarm_hour = '0; alarm_min = '0; alarm_arm = '0;
`endif
    model_reset();
    model_on = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_sec", sec_bcd, 8'h00);
    chk("init_setting", setting, 1'b0);
    chk("init_tick", tick_1hz, 1'b0);

    // Free run: ticks on cycles 10/20/30.
    run_en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("tick_at", tick_1hz, (i % 10) == 0);
    end
    chk("sec_after30", sec_bcd, 8'h03);
    chk("model_sec30", tod, 3);

    // Day rollover.
    set_req = 1'b1; step(); set_req = 1'b0;
    chk("enter_set", setting, 1'b1);
    strobe(2, 23); strobe(1, 59); strobe(0, 59);
    set_commit = 1'b1; step(); set_commit = 1'b0;
    chk("commit_setting", setting, 1'b0);
    chk("set_hour", hour_bcd, 8'h23);
    chk("set_min", min_bcd, 8'h59);
    chk("set_sec", sec_bcd, 8'h59);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("day_pulse_at", day_pulse, i == 10);
      chk("tick_at_roll", tick_1hz, i == 10);
    end
    chk("roll_hour", hour_bcd, 8'h00);
    chk("roll_min", min_bcd, 8'h00);
    chk("roll_sec", sec_bcd, 8'h00);
    chk("model_roll", tod, 0);
    step();
    chk("day_pulse_one", day_pulse, 1'b0);

    // Range errors.
    set_req = 1'b1; step(); set_req = 1'b0;
    strobe(1, 60);
    chk("err_min60", set_err, 1'b1);
    chk("min_kept", min_bcd, 8'h00);
    step();
    chk("err_clear", set_err, 1'b0);
    strobe(3, 0);
    chk("err_rsvd", set_err, 1'b1);
    step();
    chk("err_clear2", set_err, 1'b0);

    // 12 h display.
    mode_12h = 1'b1;
    strobe(2, 0);
    chk("h12_0", hour_bcd, 8'h12); chk("pm_0", is_pm, 1'b0);
    strobe(2, 12);
    chk("h12_12", hour_bcd, 8'h12); chk("pm_12", is_pm, 1'b1);
    strobe(2, 13);
    chk("h12_13", hour_bcd, 8'h01); chk("pm_13", is_pm, 1'b1);
    mode_12h = 1'b0;
    #1;
    chk("h24_13", hour_bcd, 8'h13);

    // Prescaler freeze.
    set_commit = 1'b1; step(); set_commit = 1'b0;
    for (int i = 0; i < 7; i++) step();
    run_en = 1'b0;
    for (int i = 0; i < 50; i++) step();
    run_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("freeze_tick", tick_1hz, i == 3);
    end

    // Reset in the middle of SET.
    set_req = 1'b1; step(); set_req = 1'b0;
    strobe(1, 30);
    chk("pre_rst_min", min_bcd, 8'h30);
    do_reset();
    step();
    chk("post_rst_setting", setting, 1'b0);

`ifdef TIMEKEEPER_ALARM_EN
    set_req = 1'b1; step(); set_req = 1'b0;
    strobe(2, 0); strobe(1, 0); strobe(0, 58);
    alarm_hour = 6'd0; alarm_min = 6'd1; alarm_arm = 1'b1;
    set_commit = 1'b1; step(); set_commit = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("alarm_at", alarm_fire, i == 20);
    end
    alarm_arm = 1'b0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      run_en     = ($urandom % 8) != 0;
      set_req    = ($urandom % 20) == 0;
      set_strobe = ($urandom % 3) == 0;
      set_commit = ($urandom % 10) == 0;
      set_field  = 2'($urandom);
      set_value  = ($urandom % 2 == 0) ? 6'($urandom_range(0, 23)) : 6'($urandom_range(0, 63));
      mode_12h   = 1'($urandom);
`ifdef TIMEKEEPER_ALARM_EN
      alarm_arm  = 1'($urandom);
      alarm_hour = 6'($urandom_range(0, 2));
      alarm_min  = 6'($urandom_range(0, 3));
`endif
      if ($urandom % 500 == 0) do_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
